// File: rtl/mem_port_arbiter3.sv
// Round-robin arbiter for one shared 3-way datapath port.
// Runs a valid/ready/done handshake and aborts a hung transaction via a watchdog.
module mem_port_arbiter3 #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TO_WIDTH       = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_req,
  output logic [2:0] o_gnt,
  output logic [1:0] o_sel,
  output logic       o_mem_valid,
  input  logic       i_mem_ready,
  input  logic       i_mem_done,
  output logic [2:0] o_done,
  output logic [2:0] o_err,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  localparam logic [TO_WIDTH-1:0] TLAST =
    TO_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t              state;
  logic [1:0]          last;
  logic [1:0]          win;
  logic [1:0]          pick;
  logic [1:0]          c0;
  logic [1:0]          c1;
  logic [1:0]          c2;
  logic [TO_WIDTH-1:0] timer;
  logic                expired;

  // Scan order starts one past the last winner.
  always_comb begin
    c0 = 2'd0;
    c1 = 2'd1;
    c2 = 2'd2;
    unique case (last)
      2'd0: begin
        c0 = 2'd1;
        c1 = 2'd2;
        c2 = 2'd0;
      end
      2'd1: begin
        c0 = 2'd2;
        c1 = 2'd0;
        c2 = 2'd1;
      end
      default: begin
        c0 = 2'd0;
        c1 = 2'd1;
        c2 = 2'd2;
      end
    endcase
    if (i_req[c0]) begin
      pick = c0;
    end else if (i_req[c1]) begin
      pick = c1;
    end else begin
      pick = c2;
    end
  end

  assign expired = (timer == TLAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      o_gnt       <= 3'b000;
      o_sel       <= 2'b11;
      o_mem_valid <= 1'b0;
      o_done      <= 3'b000;
      o_err       <= 3'b000;
      o_busy      <= 1'b0;
      last        <= 2'd2;
      win         <= 2'd0;
      timer       <= '0;
    end else begin
      o_done <= 3'b000;
      o_err  <= 3'b000;
      unique case (state)
        S_IDLE: begin
          if (|i_req) begin
            win         <= pick;
            o_gnt       <= 3'b001 << pick;
            o_sel       <= pick;
            o_mem_valid <= 1'b1;
            o_busy      <= 1'b1;
            timer       <= '0;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT: begin
          timer <= timer + 1'b1;
          // Completion outranks both the watchdog and a late ready.
          if (i_mem_done || expired) begin
            o_done      <= i_mem_done ? o_gnt : 3'b000;
            o_err       <= i_mem_done ? 3'b000 : o_gnt;
            o_gnt       <= 3'b000;
            o_sel       <= 2'b11;
            o_mem_valid <= 1'b0;
            o_busy      <= 1'b0;
            last        <= win;
            timer       <= '0;
            state       <= S_IDLE;
          end else if (state == S_ISSUE && i_mem_ready) begin
            o_mem_valid <= 1'b0;
            state       <= S_WAIT;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter3.sv
// Directed bench for mem_port_arbiter3: dut_a default watchdog,
// dut_b with a 4-cycle watchdog; grant/completion scoreboard queues.
module tb_mem_port_arbiter3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] req_a, req_b;
  logic       rdy_a, rdy_b;
  logic       dn_a, dn_b;
  logic [2:0] gnt_a, gnt_b;
  logic [1:0] sel_a, sel_b;
  logic       mv_a, mv_b;
  logic [2:0] done_a, done_b;
  logic [2:0] err_a, err_b;
  logic       busy_a, busy_b;

  int tests = 0;
  int fails = 0;
  int c;

  logic [2:0] gq[$];
  logic [5:0] cq[$];

  mem_port_arbiter3 dut_a (
    .i_clk(clk), .i_rst(rst), .i_req(req_a),
    .o_gnt(gnt_a), .o_sel(sel_a), .o_mem_valid(mv_a),
    .i_mem_ready(rdy_a), .i_mem_done(dn_a),
    .o_done(done_a), .o_err(err_a), .o_busy(busy_a)
  );

  mem_port_arbiter3 #(
    .TIMEOUT_CYCLES(4),
    .TO_WIDTH(8)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_req(req_b),
    .o_gnt(gnt_b), .o_sel(sel_b), .o_mem_valid(mv_b),
    .i_mem_ready(rdy_b), .i_mem_done(dn_b),
    .o_done(done_b), .o_err(err_b), .o_busy(busy_b)
  );

  function automatic logic [2:0] gnt_of(input bit b);
    return b ? gnt_b : gnt_a;
  endfunction

  function automatic logic [1:0] sel_of(input bit b);
    return b ? sel_b : sel_a;
  endfunction

  function automatic logic [5:0] cpl_of(input bit b);
    return b ? {done_b, err_b} : {done_a, err_a};
  endfunction

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic wait_gnt(input bit b, input string tag,
                          output int cyc);
    logic [2:0] want;
    logic [1:0] idx;
    want = gq.pop_front();
    idx  = want[2] ? 2'd2 : (want[1] ? 2'd1 : 2'd0);
    cyc  = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      cyc++;
      if (gnt_of(b) != 3'b000) break;
    end
    chk({tag, " gnt"}, 8'(gnt_of(b)), 8'(want));
    chk({tag, " sel"}, 8'(sel_of(b)), 8'(idx));
  endtask

  task automatic wait_cpl(input bit b, input string tag,
                          output int cyc);
    logic [5:0] want;
    want = cq.pop_front();
    cyc  = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      cyc++;
      if (cpl_of(b) != 6'b0) break;
    end
    chk({tag, " done/err"}, 8'(cpl_of(b)), 8'(want));
    chk({tag, " gnt rel"}, 8'(gnt_of(b)), 8'h0);
    chk({tag, " sel idle"}, 8'(sel_of(b)), 8'h3);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    req_a = 3'b111;
    req_b = 3'b000;
    rdy_a = 1'b0;
    dn_a  = 1'b0;
    rdy_b = 1'b0;
    dn_b  = 1'b0;

    // reset held two cycles with all requests up
    repeat (2) begin
      @(negedge clk);
      chk("rst sel", 8'(sel_a), 8'h3);
      chk("rst gnt", 8'(gnt_a), 8'h0);
      chk("rst busy", 8'(busy_a), 8'h0);
    end
    chk("rst valid", 8'(mv_a), 8'h0);
    chk("rst cpl", 8'({done_a, err_a}), 8'h0);
    chk("rst b sel", 8'(sel_b), 8'h3);

    // single request from ldst
    rst   = 1'b0;
    req_a = 3'b010;
    gq.push_back(3'b010);
    wait_gnt(1'b0, "single", c);
    chk("single lat", 8'(c), 8'd1);
    chk("single valid", 8'(mv_a), 8'h1);
    chk("single busy", 8'(busy_a), 8'h1);
    @(negedge clk);
    rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    chk("single valid drop", 8'(mv_a), 8'h0);
    chk("single sel hold", 8'(sel_a), 8'h1);
    @(negedge clk);
    @(negedge clk);
    dn_a = 1'b1;
    cq.push_back({3'b010, 3'b000});
    wait_cpl(1'b0, "single", c);
    dn_a  = 1'b0;
    req_a = 3'b000;
    @(negedge clk);
    chk("single pulse", 8'(done_a), 8'h0);
    chk("single idle", 8'(busy_a), 8'h0);

    // fairness from a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    req_a = 3'b111;
    rdy_a = 1'b1;
    dn_a  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      gq.push_back(3'b001 << (i % 3));
      cq.push_back({3'(3'b001 << (i % 3)), 3'b000});
    end
    for (int i = 0; i < 6; i++) begin
      wait_gnt(1'b0, "rr", c);
      chk("rr bubble", 8'(c), 8'd1);
      wait_cpl(1'b0, "rr", c);
      chk("rr cpl lat", 8'(c), 8'd1);
      if (i == 5) begin
        req_a = 3'b000;
        rdy_a = 1'b0;
        dn_a  = 1'b0;
      end
    end
    @(negedge clk);
    chk("rr stop", 8'(busy_a), 8'h0);

    // reset in WAIT aborts silently
    req_a = 3'b010;
    gq.push_back(3'b010);
    wait_gnt(1'b0, "mid", c);
    @(negedge clk);
    rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    chk("mid in wait", 8'(mv_a), 8'h0);
    req_a = 3'b111;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid busy", 8'(busy_a), 8'h0);
    chk("mid sel", 8'(sel_a), 8'h3);
    chk("mid cpl", 8'({done_a, err_a}), 8'h0);
    gq.push_back(3'b001);
    wait_gnt(1'b0, "mid next", c);
    chk("mid next lat", 8'(c), 8'd1);
    chk("mid quiet", 8'({done_a, err_a}), 8'h0);
    dn_a = 1'b1;
    cq.push_back({3'b001, 3'b000});
    wait_cpl(1'b0, "mid", c);
    dn_a  = 1'b0;
    req_a = 3'b000;

    // watchdog on the 4-cycle instance
    req_b = 3'b011;
    gq.push_back(3'b001);
    wait_gnt(1'b1, "to", c);
    chk("to valid", 8'(mv_b), 8'h1);
    cq.push_back({3'b000, 3'b001});
    wait_cpl(1'b1, "to", c);
    chk("to lat", 8'(c), 8'd4);
    chk("to valid drop", 8'(mv_b), 8'h0);
    gq.push_back(3'b010);
    wait_gnt(1'b1, "to next", c);
    chk("to next lat", 8'(c), 8'd1);

    // done on the final watchdog cycle wins
    @(negedge clk);
    rdy_b = 1'b1;
    @(negedge clk);
    rdy_b = 1'b0;
    chk("race wait", 8'(mv_b), 8'h0);
    @(negedge clk);
    dn_b = 1'b1;
    cq.push_back({3'b010, 3'b000});
    wait_cpl(1'b1, "race", c);
    chk("race lat", 8'(c), 8'd1);
    dn_b  = 1'b0;
    req_b = 3'b000;
    @(negedge clk);
    chk("race no err", 8'({done_b, err_b}), 8'h0);
    chk("race idle", 8'(busy_b), 8'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
